bbox_overlay: RTL and testbench
===============================

# bbox_overlay

Post-processing stage that sits directly downstream of the `vb` vision block and consumes its binary RGB stream. It accumulates the bounding box of all foreground (nonzero) pixels over one frame and latches it at the frame boundary. During the following frame it draws that box as a 1-pixel border onto the passing video. It also exposes the latched box coordinates as status outputs, and feeds the HDMI output stage.

## Interface
Parameters:
- `CW`, 11, coordinate width for the x/y counters and box registers.
- `MIN_PIXELS`, 16, minimum foreground pixel count for a box to be declared valid.
- `BOX_COLOR`, 24'hFF0000, RGB value drawn on border pixels.

Ports:
- `clk` in 1: pixel clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_de` in 1: data enable from `vb`.
- `in_hsync` in 1: horizontal sync.
- `in_vsync` in 1: vertical sync, active-high.
- `in_pixel` in 24: {R,G,B}; foreground = any nonzero bit.
- `out_de`, `out_hsync`, `out_vsync` out 1: inputs delayed 1 cycle.
- `out_pixel` out 24: video with overlay.
- `box_valid` out 1: latched box is valid.
- `box_x_min`, `box_x_max`, `box_y_min`, `box_y_max` out CW: latched box coordinates.

## Operation
- **Column counter `x`**
  - Increments on each `in_de`=1 cycle.
  - Cleared while `in_de`=0.
  - Saturates at 2^CW-1.
- **Row counter `y`**
  - Increments on each falling edge of `in_de`.
  - Cleared on the `in_vsync` rising edge.
  - Saturates at 2^CW-1.
- **Accumulators**
  - `acc_xmin` and `acc_ymin` reset to all-ones; `acc_xmax` and `acc_ymax` reset to 0.
  - `acc_cnt` is 2*CW bits, saturating.
  - Updated on every cycle with `in_de`=1 and `in_pixel`≠0, using the current `x`/`y`.
- **Frame end**
  - Trigger: `in_vsync` rising edge, detected against a registered copy of `in_vsync`.
  - A pixel presented on the edge cycle itself is included in the ending frame.
  - On the next cycle, if `armed`=1:
    - `box_valid` ← (`acc_cnt` ≥ `MIN_PIXELS`).
    - Box registers ← accumulators, but only when the count condition holds. Otherwise the old coordinates are held and `box_valid`=0.
  - Accumulators and `y` are then re-initialised.
- **`armed` flag**
  - Cleared by reset.
  - Set by the first `in_vsync` rising edge.
  - Effect: the partial frame in progress at reset release is discarded, never latched.
- **Overlay**
  - Applies when `box_valid`=1 and `in_de`=1.
  - A pixel is a border pixel when either:
    - (`x`==`box_x_min` or `x`==`box_x_max`) and `box_y_min` ≤ `y` ≤ `box_y_max`; or
    - (`y`==`box_y_min` or `y`==`box_y_max`) and `box_x_min` ≤ `x` ≤ `box_x_max`.
  - Border pixels are replaced by `BOX_COLOR`; all other pixels pass through unchanged.
  - When `in_de`=0, `out_pixel` = `in_pixel`, registered.
- **State:** the only control state is `armed` (IDLE → ARMED); there is no other FSM.

## Timing
- **Reset values:** every output is 0. `armed`=0, accumulators at their reset values, `x`=`y`=0.
- **Pixel-path latency:** exactly 1 cycle for `de`, `hsync`, `vsync` and `pixel`, identical for all four.
- **Status outputs:** update 2 cycles after the `in_vsync` rising edge and hold stable until the next frame end.
- **Overlay source:** uses the box from the previous frame only, never a partially accumulated one.
- **Reset mid-frame:** all state clears immediately and asynchronously. The next latch happens only at the second `in_vsync` rising edge after release.
- **Empty frame:** no foreground pixels gives `box_valid`=0 at frame end.
- **Degenerate boxes:** a single-pixel box (min==max) draws a single pixel.

## Configuration
- `BBOX_CROSSHAIR_EN`
  - **Defined:** also draws a 1-pixel crosshair in `BOX_COLOR` at cx=(`box_x_min`+`box_x_max`)>>1 and cy=(`box_y_min`+`box_y_max`)>>1.
    - The sum is computed CW+1 wide before the shift.
    - The crosshair is clipped to the box interior.
    - cx and cy are registered at frame end together with the box, so latency is unchanged.
  - **Undefined:** border only; no centre logic is synthesised.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs → all outputs 0. Release mid-frame, then run one full 16x8 frame with foreground → `box_valid` stays 0.
- **Box latch:** 16x8 frames, foreground at x 3..6, y 2..4 (12 px), `MIN_PIXELS`=12 → after the second vsync edge, box = (3,6,2,4) and `box_valid`=1. The next frame outputs `BOX_COLOR` at exactly the 10 border pixels; interior (4..5,3) passes through.
- **Below threshold:** same frame with `MIN_PIXELS`=13 → `box_valid`=0, output equals input delayed 1 cycle.
- **Single pixel:** one foreground pixel at (15,7), `MIN_PIXELS`=1 → box (15,15,7,7); exactly one replaced pixel in the next frame.
- **Latency:** random sync/de pattern → `out_de`/`out_hsync`/`out_vsync` equal the inputs delayed exactly 1 cycle for the whole run.
- **Crosshair:** with `BBOX_CROSSHAIR_EN` and box (2,9,1,6) → cx=5, cy=3. Column 5 over y 2..5 and row 3 over x 3..8 are `BOX_COLOR`.

Source files
------------

// File: rtl/bbox_overlay.sv
// bbox_overlay: accumulates the bounding box of foreground pixels over a frame,
// latches it at the vsync rising edge and draws it as a 1-pixel border on the
// following frame. The latched box coordinates are also exposed as status outputs.
// Optional build macro: BBOX_CROSSHAIR_EN adds a centre crosshair, clipped to the
// box interior and drawn in BOX_COLOR.
module bbox_overlay #(
  parameter int          CW         = 11,
  parameter int          MIN_PIXELS = 16,
  parameter logic [23:0] BOX_COLOR  = 24'hFF0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_de,
  input  logic          in_hsync,
  input  logic          in_vsync,
  input  logic [23:0]   in_pixel,
  output logic          out_de,
  output logic          out_hsync,
  output logic          out_vsync,
  output logic [23:0]   out_pixel,
  output logic          box_valid,
  output logic [CW-1:0] box_x_min,
  output logic [CW-1:0] box_x_max,
  output logic [CW-1:0] box_y_min,
  output logic [CW-1:0] box_y_max
);

  localparam int            CNT_W   = 2 * CW;
  localparam logic [CW-1:0] C_ONES  = '1;
  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_ARMED = 1'b1;

  function automatic logic [CW-1:0] sat_inc_c(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_n(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [0:0]       state;
  logic             de_p0;
  logic             vs_p0;
  logic             fe_p0;
  logic [CW-1:0]    x;
  logic [CW-1:0]    y;
  logic [CW-1:0]    acc_xmin;
  logic [CW-1:0]    acc_xmax;
  logic [CW-1:0]    acc_ymin;
  logic [CW-1:0]    acc_ymax;
  logic [CNT_W-1:0] acc_cnt;
  logic             vs_rise;
  logic             de_fall;
  logic             fg;
  logic             cnt_ok;
  logic             border;
  logic             draw;
`ifdef BBOX_CROSSHAIR_EN
  logic [CW-1:0]    cx;
  logic [CW-1:0]    cy;
  logic [CW:0]      sum_x;
  logic [CW:0]      sum_y;
`endif

  assign vs_rise = in_vsync & ~vs_p0;
  assign de_fall = ~in_de & de_p0;
  assign fg      = in_de & (|in_pixel);
  assign cnt_ok  = (acc_cnt >= CNT_W'(MIN_PIXELS));

`ifdef BBOX_CROSSHAIR_EN
  // Centre sums are one bit wider so the midpoint never wraps.
  assign sum_x = {1'b0, acc_xmin} + {1'b0, acc_xmax};
  assign sum_y = {1'b0, acc_ymin} + {1'b0, acc_ymax};
`endif

  // Edge detectors, frame-end pulse and the IDLE -> ARMED flag.
  // Arming happens on the first frame end, so the partial frame at reset release is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_p0 <= 1'b0;
      vs_p0 <= 1'b0;
      fe_p0 <= 1'b0;
      state <= S_IDLE;
    end else begin
      de_p0 <= in_de;
      vs_p0 <= in_vsync;
      fe_p0 <= vs_rise;
      if (fe_p0)
        state <= S_ARMED;
    end
  end

  // Column and row counters; the pixel on the current cycle is at (x, y).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= in_de ? sat_inc_c(x) : '0;
      if (vs_rise)
        y <= '0;
      else if (de_fall)
        y <= sat_inc_c(y);
    end
  end

  // Foreground accumulators. A pixel on the vsync edge cycle still belongs to the
  // ending frame; a pixel on the frame-end cycle seeds the freshly cleared set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_xmin <= C_ONES;
      acc_xmax <= '0;
      acc_ymin <= C_ONES;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (fe_p0) begin
      acc_xmin <= fg ? x : C_ONES;
      acc_xmax <= fg ? x : '0;
      acc_ymin <= fg ? y : C_ONES;
      acc_ymax <= fg ? y : '0;
      acc_cnt  <= fg ? CNT_W'(1) : '0;
    end else if (fg) begin
      if (x < acc_xmin) acc_xmin <= x;
      if (x > acc_xmax) acc_xmax <= x;
      if (y < acc_ymin) acc_ymin <= y;
      if (y > acc_ymax) acc_ymax <= y;
      acc_cnt <= sat_inc_n(acc_cnt);
    end
  end

  // Box latch at frame end; coordinates are held when the count is too low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_valid <= 1'b0;
      box_x_min <= '0;
      box_x_max <= '0;
      box_y_min <= '0;
      box_y_max <= '0;
`ifdef BBOX_CROSSHAIR_EN
      cx        <= '0;
      cy        <= '0;
`endif
    end else if (fe_p0 && (state == S_ARMED)) begin
      box_valid <= cnt_ok;
      if (cnt_ok) begin
        box_x_min <= acc_xmin;
        box_x_max <= acc_xmax;
        box_y_min <= acc_ymin;
        box_y_max <= acc_ymax;
`ifdef BBOX_CROSSHAIR_EN
        cx        <= sum_x[CW:1];
        cy        <= sum_y[CW:1];
`endif
      end
    end
  end

  // Border (and optional crosshair) hit test against the previously latched box.
  always_comb begin
    border = (((x == box_x_min) || (x == box_x_max)) &&
              (y >= box_y_min) && (y <= box_y_max)) ||
             (((y == box_y_min) || (y == box_y_max)) &&
              (x >= box_x_min) && (x <= box_x_max));
`ifdef BBOX_CROSSHAIR_EN
    border = border ||
             ((x == cx) && (y > box_y_min) && (y < box_y_max)) ||
             ((y == cy) && (x > box_x_min) && (x < box_x_max));
`endif
    draw = box_valid & in_de & border;
  end

  // Output stage: one-cycle delay for sync, enable and the overlaid pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_de    <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_pixel <= '0;
    end else begin
      out_de    <= in_de;
      out_hsync <= in_hsync;
      out_vsync <= in_vsync;
      out_pixel <= draw ? BOX_COLOR : in_pixel;
    end
  end

endmodule

// File: tb/tb_bbox_overlay.sv
// Testbench for bbox_overlay: two instances (MIN_PIXELS 12 and 1) share one
// stimulus stream; a frame-level reference model predicts every output each cycle.
module tb_bbox_overlay;
  localparam int          CW   = 11;
  localparam int          MAXC = (1 << CW) - 1;
  localparam logic [23:0] BOX  = 24'hFF0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_de = 1'b0;
  logic          in_hsync = 1'b0;
  logic          in_vsync = 1'b0;
  logic [23:0]   in_pixel = '0;
  logic          a_de, a_hs, a_vs, a_valid, b_de, b_hs, b_vs, b_valid;
  logic [23:0]   a_pix, b_pix;
  logic [CW-1:0] a_x0, a_x1, a_y0, a_y1, b_x0, b_x1, b_y0, b_y1;

  int tests = 0;
  int fails = 0;
  int rep_a = 0;
  int rep_b = 0;

  bbox_overlay #(.CW(CW), .MIN_PIXELS(12), .BOX_COLOR(BOX)) u_a (
    .clk(clk), .rst_n(rst_n), .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_pixel(in_pixel), .out_de(a_de), .out_hsync(a_hs), .out_vsync(a_vs),
    .out_pixel(a_pix), .box_valid(a_valid), .box_x_min(a_x0), .box_x_max(a_x1),
    .box_y_min(a_y0), .box_y_max(a_y1));

  bbox_overlay #(.CW(CW), .MIN_PIXELS(1), .BOX_COLOR(BOX)) u_b (
    .clk(clk), .rst_n(rst_n), .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_pixel(in_pixel), .out_de(b_de), .out_hsync(b_hs), .out_vsync(b_vs),
    .out_pixel(b_pix), .box_valid(b_valid), .box_x_min(b_x0), .box_x_max(b_x1),
    .box_y_min(b_y0), .box_y_max(b_y1));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          mx, my;
  bit          m_de_prev, m_vs_prev, m_pend, m_armed;
  int          fq_x[$];
  int          fq_y[$];
  int          min_px[2] = '{12, 1};
  bit          mv[2];
  int          bx0[2], bx1[2], by0[2], by1[2];
  bit          e_de, e_hs, e_vs;
  logic [23:0] e_pix[2];

  function automatic bit on_box(input int i, input int px, input int py);
    bit hit;
    hit = ((px == bx0[i] || px == bx1[i]) && py >= by0[i] && py <= by1[i]) ||
          ((py == by0[i] || py == by1[i]) && px >= bx0[i] && px <= bx1[i]);
`ifdef BBOX_CROSSHAIR_EN
    hit = hit ||
          (px == (bx0[i] + bx1[i]) / 2 && py > by0[i] && py < by1[i]) ||
          (py == (by0[i] + by1[i]) / 2 && px > bx0[i] && px < bx1[i]);
`endif
    return hit;
  endfunction

  task automatic latch_box(input int i);
    int n, x0, x1, y0, y1;
    n = fq_x.size();
    x0 = MAXC; x1 = 0; y0 = MAXC; y1 = 0;
    for (int k = 0; k < n; k++) begin
      if (fq_x[k] < x0) x0 = fq_x[k];
      if (fq_x[k] > x1) x1 = fq_x[k];
      if (fq_y[k] < y0) y0 = fq_y[k];
      if (fq_y[k] > y1) y1 = fq_y[k];
    end
    mv[i] = (n >= min_px[i]);
    if (mv[i]) begin
      bx0[i] = x0; bx1[i] = x1; by0[i] = y0; by1[i] = y1;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      mx = 0; my = 0; m_de_prev = 0; m_vs_prev = 0; m_pend = 0; m_armed = 0;
      fq_x.delete(); fq_y.delete();
      e_de = 0; e_hs = 0; e_vs = 0;
      for (int i = 0; i < 2; i++) begin
        mv[i] = 0; bx0[i] = 0; bx1[i] = 0; by0[i] = 0; by1[i] = 0; e_pix[i] = '0;
      end
    end else begin
      e_de = in_de; e_hs = in_hsync; e_vs = in_vsync;
      for (int i = 0; i < 2; i++)
        e_pix[i] = (mv[i] && in_de && on_box(i, mx, my)) ? BOX : in_pixel;
      if (m_pend) begin
        if (m_armed)
          for (int i = 0; i < 2; i++) latch_box(i);
        m_armed = 1;
        fq_x.delete(); fq_y.delete();
      end
      if (in_de && in_pixel != 24'h0) begin
        fq_x.push_back(mx); fq_y.push_back(my);
      end
      m_pend = in_vsync && !m_vs_prev;
      if (in_vsync && !m_vs_prev) my = 0;
      else if (!in_de && m_de_prev && my < MAXC) my = my + 1;
      mx = in_de ? ((mx < MAXC) ? mx + 1 : mx) : 0;
      m_de_prev = in_de; m_vs_prev = in_vsync;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    logic [71:0] got, ex;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) got = {a_de, a_hs, a_vs, a_pix, a_valid, a_x0, a_x1, a_y0, a_y1};
      else        got = {b_de, b_hs, b_vs, b_pix, b_valid, b_x0, b_x1, b_y0, b_y1};
      if (!rst_n) ex = '0;
      else ex = {e_de, e_hs, e_vs, e_pix[i], mv[i], CW'(bx0[i]), CW'(bx1[i]),
                 CW'(by0[i]), CW'(by1[i])};
      tests++;
      if (got !== ex) begin
        fails++;
        $display("FAIL cycle_cmp dut%0d t=%0t got=%h expected=%h", i, $time, got, ex);
      end
    end
    if (a_de && a_pix == BOX) rep_a++;
    if (b_de && b_pix == BOX) rep_b++;
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] rnd_nz();
    logic [23:0] v;
    v = 24'($urandom);
    if (v == 24'h0 || v == BOX) v = 24'h00A5C3;
    return v;
  endfunction

  function automatic bit is_fg(input int kind, input int c, input int r);
    case (kind)
      1: return (c >= 3 && c <= 6 && r >= 2 && r <= 4);
      2: return (c >= 3 && c <= 6 && r >= 2 && r <= 4) && !(c == 6 && r == 4);
      3: return (c == 15 && r == 7);
      4: return (c == 2 && r == 1) || (c == 9 && r == 6);
      5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_frame(input int kind, input int row_start);
    for (int r = row_start; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        in_de = 1'b1;
        in_pixel = is_fg(kind, c, r) ? rnd_nz() : 24'h0;
        tick();
      end
      in_de = 1'b0; in_pixel = 24'h0; in_hsync = 1'b1;
      tick(); tick();
      in_hsync = 1'b0;
      tick(); tick();
    end
    tick(); tick(); tick();
    in_vsync = 1'b1;
    tick(); tick(); tick();
    in_vsync = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    // reset with random inputs
    for (int k = 0; k < 6; k++) begin
      in_de = 1'($urandom); in_hsync = 1'($urandom); in_vsync = 1'($urandom);
      in_pixel = 24'($urandom);
      tick();
      chk("rst_out_pixel", int'(a_pix), 0);
      chk("rst_out_sync", int'({a_de, a_hs, a_vs, b_de, b_hs, b_vs}), 0);
      chk("rst_box", int'({a_valid, a_x0, a_y1, b_valid, b_x1}), 0);
    end
    in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_pixel = 24'h0;
    tick();
    rst_n = 1'b1;

    // partial frame at release is discarded; first full frame latches at 2nd edge
    drive_frame(1, 3);
    chk("partial_valid", int'(a_valid), 0);
    chk("partial_valid_b", int'(b_valid), 0);
    drive_frame(1, 0);
    chk("latch_valid", int'(a_valid), 1);
    chk("latch_x_min", int'(a_x0), 3);
    chk("latch_x_max", int'(a_x1), 6);
    chk("latch_y_min", int'(a_y0), 2);
    chk("latch_y_max", int'(a_y1), 4);
    chk("latch_b_box", int'({b_x0, b_x1, b_y0, b_y1}), int'({11'd3, 11'd6, 11'd2, 11'd4}));

    rep_a = 0; rep_b = 0;
    drive_frame(5, 0);
    chk("border_count_a", rep_a, 10);
    chk("border_count_b", rep_b, 10);

    // 11 pixels: below threshold for MIN_PIXELS=12, coordinates held
    drive_frame(2, 0);
    chk("below_valid_a", int'(a_valid), 0);
    chk("below_held_x_max", int'(a_x1), 15);
    chk("below_held_y_max", int'(a_y1), 7);
    chk("below_valid_b", int'(b_valid), 1);
    chk("below_b_x_max", int'(b_x1), 6);
    rep_a = 0; rep_b = 0;
    drive_frame(5, 0);
    chk("below_no_overlay_a", rep_a, 0);
    chk("below_overlay_b", rep_b, 10);

    // single pixel at (15,7)
    drive_frame(3, 0);
    chk("single_valid_b", int'(b_valid), 1);
    chk("single_box_b", int'({b_x0, b_x1, b_y0, b_y1}), int'({11'd15, 11'd15, 11'd7, 11'd7}));
    chk("single_valid_a", int'(a_valid), 0);
    rep_a = 0; rep_b = 0;
    drive_frame(5, 0);
    chk("single_replaced_b", rep_b, 1);
    chk("single_replaced_a", rep_a, 0);

    // empty frame
    drive_frame(0, 0);
    chk("empty_valid_b", int'(b_valid), 0);
    chk("empty_valid_a", int'(a_valid), 0);

`ifdef BBOX_CROSSHAIR_EN
    drive_frame(4, 0);
    chk("cross_box_b", int'({b_x0, b_x1, b_y0, b_y1}), int'({11'd2, 11'd9, 11'd1, 11'd6}));
    rep_a = 0; rep_b = 0;
    drive_frame(5, 0);
    chk("cross_replaced_b", rep_b, 33);
`endif

    // random sync/de/pixel stream with a mid-run asynchronous reset
    for (int k = 0; k < 3000; k++) begin
      in_de = ($urandom_range(0, 9) < 7);
      in_hsync = 1'($urandom);
      if ($urandom_range(0, 39) == 0) in_vsync = ~in_vsync;
      in_pixel = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'h0;
      if (k == 1500) begin
        #2 rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    in_de = 1'b0; in_vsync = 1'b0; in_pixel = 24'h0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
